// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: sequencer step codes,
// opcode constants and the retired-instruction counter width.
package cpu_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned ICNT_W  = 16;

    // Step codes consumed by the control-output decoder.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_LOAD   = 4'h2,
        S_MOVE   = 4'h3,
        S_LDPC   = 4'h4,
        S_BRANCH = 4'h5,
        S_SUB0   = 4'h6,
        S_SUB1   = 4'h7,
        S_SUB2   = 4'h8,
        S_ADD0   = 4'h9,
        S_ADD1   = 4'hA,
        S_ADD2   = 4'hB,
        S_XOR0   = 4'hC,
        S_XOR1   = 4'hD,
        S_XOR2   = 4'hE,
        S_IDLE   = 4'hF
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 4'h1;
    localparam logic [OP_W-1:0] OP_MOVE   = 4'h2;
    localparam logic [OP_W-1:0] OP_LDPC   = 4'h3;
    localparam logic [OP_W-1:0] OP_BRANCH = 4'h4;
    localparam logic [OP_W-1:0] OP_ADD    = 4'h5;
    localparam logic [OP_W-1:0] OP_SUB    = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR    = 4'h7;
    localparam logic [OP_W-1:0] OP_HALT   = 4'hF;

    // True for the final step of every instruction.
    function automatic logic is_last_step(input state_t s);
        case (s)
            S_LOAD, S_MOVE, S_LDPC, S_BRANCH, S_ADD2, S_SUB2, S_XOR2: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode classifier for the DECODE step.
// Ports:
//   i_op      : opcode field instr[15:12]
//   o_defined : opcode maps to a real instruction group
//   o_halt    : opcode is the halt instruction (only with CTRL_HALT_OPCODE_EN)
//   o_target  : first step of the selected instruction group
// Build option: CTRL_HALT_OPCODE_EN makes opcode F a halt; otherwise F is undefined.
module opcode_classify
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    output logic            o_defined,
    output logic            o_halt,
    output state_t          o_target
);

    // Group select; undefined opcodes fall back to FETCH as a harmless target.
    always_comb begin
        o_defined = 1'b1;
        o_target  = S_FETCH;
        case (i_op)
            OP_LOAD:   o_target = S_LOAD;
            OP_MOVE:   o_target = S_MOVE;
            OP_LDPC:   o_target = S_LDPC;
            OP_BRANCH: o_target = S_BRANCH;
            OP_ADD:    o_target = S_ADD0;
            OP_SUB:    o_target = S_SUB0;
            OP_XOR:    o_target = S_XOR0;
            default:   o_defined = 1'b0;
        endcase
    end

`ifdef CTRL_HALT_OPCODE_EN
    assign o_halt = (i_op == OP_HALT);
`else
    assign o_halt = 1'b0;
`endif

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE and the per-opcode
// execute steps, counts retired instructions and flags illegal opcodes.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   run          : permits leaving IDLE / starting the next fetch
//   instr_op     : opcode field, only looked at in DECODE
//   state        : registered step code
//   busy         : state != IDLE
//   instr_done   : one-cycle pulse per retired instruction
//   illegal      : one-cycle pulse after an undefined opcode
//   pc_bump      : combinational, high in DECODE with an undefined opcode
//   halted       : sticky halt flag (constant 0 unless CTRL_HALT_OPCODE_EN)
//   instr_count  : retired-instruction counter, wraps
// Build option: CTRL_HALT_OPCODE_EN enables opcode F as a halt instruction.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [OP_W-1:0]    instr_op,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               instr_done,
    output logic               illegal,
    output logic               pc_bump,
    output logic               halted,
    output logic [ICNT_W-1:0]  instr_count
);

    state_t              r_state;
    logic                r_instr_done;
    logic                r_illegal;
    logic                r_halted;
    logic [ICNT_W-1:0]   r_count;

    logic                w_defined;
    logic                w_halt;
    state_t              w_target;

    opcode_classify u_classify (
        .i_op      (instr_op),
        .o_defined (w_defined),
        .o_halt    (w_halt),
        .o_target  (w_target)
    );

    // Sequencer, retire counter and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_instr_done <= 1'b0;
            r_illegal    <= 1'b0;
            r_halted     <= 1'b0;
            r_count      <= '0;
        end else begin
            r_instr_done <= 1'b0;
            r_illegal    <= 1'b0;
            if (is_last_step(r_state)) begin
                r_instr_done <= 1'b1;
                r_count      <= r_count + ICNT_W'(1);
                r_state      <= run ? S_FETCH : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:   if (run && !r_halted) r_state <= S_FETCH;
                    S_FETCH:  r_state <= S_DECODE;
                    S_DECODE: begin
                        if (w_halt) begin
                            // Halt retires like an instruction, then parks in IDLE.
                            r_state      <= S_IDLE;
                            r_halted     <= 1'b1;
                            r_instr_done <= 1'b1;
                            r_count      <= r_count + ICNT_W'(1);
                        end else if (w_defined) begin
                            r_state <= w_target;
                        end else begin
                            r_illegal <= 1'b1;
                            r_state   <= run ? S_FETCH : S_IDLE;
                        end
                    end
                    S_SUB0:   r_state <= S_SUB1;
                    S_SUB1:   r_state <= S_SUB2;
                    S_ADD0:   r_state <= S_ADD1;
                    S_ADD1:   r_state <= S_ADD2;
                    S_XOR0:   r_state <= S_XOR1;
                    S_XOR1:   r_state <= S_XOR2;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign state       = r_state;
    assign busy        = (r_state != S_IDLE);
    assign instr_done  = r_instr_done;
    assign illegal     = r_illegal;
    assign halted      = r_halted;
    assign instr_count = r_count;
    // Lets the PC skip an undefined instruction word within the DECODE cycle.
    assign pc_bump     = (r_state == S_DECODE) && !w_defined && !w_halt;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [3:0]  instr_op;
    logic [3:0]  state;
    logic        busy;
    logic        instr_done;
    logic        illegal;
    logic        pc_bump;
    logic        halted;
    logic [15:0] instr_count;

    int n_checks;
    int n_errors;

    control_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr_op    (instr_op),
        .state       (state),
        .busy        (busy),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .pc_bump     (pc_bump),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_expect(input string tag, input logic [3:0] exp_state);
        tick();
        check(tag, 32'(state), 32'(exp_state));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int done_seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        run      = 1'b0;
        instr_op = 4'h0;

        // Reset state
        tick();
        check("rst_state",  32'(state), 32'hF);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_count",  32'(instr_count), 32'd0);
        check("rst_done",   32'(instr_done), 32'd0);
        check("rst_illegal",32'(illegal), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pcbump", 32'(pc_bump), 32'd0);

        // ADD: 0000,0001,1001,1010,1011,0000 with one done pulse
        reset = 1'b0; run = 1'b1; instr_op = 4'h5;
        done_seen = 0;
        step_expect("add_fetch", 4'h0);  done_seen += int'(instr_done);
        check("add_busy", 32'(busy), 32'd1);
        step_expect("add_decode", 4'h1); done_seen += int'(instr_done);
        check("add_pcbump", 32'(pc_bump), 32'd0);
        step_expect("add0", 4'h9);       done_seen += int'(instr_done);
        step_expect("add1", 4'hA);       done_seen += int'(instr_done);
        step_expect("add2", 4'hB);       done_seen += int'(instr_done);
        step_expect("add_next", 4'h0);   done_seen += int'(instr_done);
        check("add_done_at_end", 32'(instr_done), 32'd1);
        check("add_done_total", 32'(done_seen), 32'd1);
        check("add_count", 32'(instr_count), 32'd1);

        // LOAD then LDPC
        do_reset();
        instr_op = 4'h1;
        step_expect("ld_fetch", 4'h0);
        step_expect("ld_decode", 4'h1);
        step_expect("ld_load", 4'h2);
        instr_op = 4'h3;
        step_expect("ldpc_fetch", 4'h0);
        check("ld_count", 32'(instr_count), 32'd1);
        step_expect("ldpc_decode", 4'h1);
        check("ldpc_done_clear", 32'(instr_done), 32'd0);
        step_expect("ldpc_ldpc", 4'h4);
        step_expect("ldpc_next", 4'h0);
        check("ldpc_count", 32'(instr_count), 32'd2);

        // Undefined opcode 9
        do_reset();
        instr_op = 4'h9;
        step_expect("ill_fetch", 4'h0);
        step_expect("ill_decode", 4'h1);
        check("ill_pcbump", 32'(pc_bump), 32'd1);
        check("ill_early", 32'(illegal), 32'd0);
        step_expect("ill_next", 4'h0);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_pcbump_off", 32'(pc_bump), 32'd0);
        check("ill_count", 32'(instr_count), 32'd0);
        check("ill_nodone", 32'(instr_done), 32'd0);
        step_expect("ill_decode2", 4'h1);
        check("ill_pulse_end", 32'(illegal), 32'd0);

        // Reset in SUB1 after one retired LOAD
        do_reset();
        instr_op = 4'h1;
        step_expect("rs_fetch", 4'h0);
        step_expect("rs_decode", 4'h1);
        step_expect("rs_load", 4'h2);
        instr_op = 4'h6;
        step_expect("rs_fetch2", 4'h0);
        check("rs_count1", 32'(instr_count), 32'd1);
        step_expect("rs_decode2", 4'h1);
        step_expect("rs_sub0", 4'h6);
        step_expect("rs_sub1", 4'h7);
        reset = 1'b1;
        step_expect("rs_after", 4'hF);
        check("rs_count0", 32'(instr_count), 32'd0);
        check("rs_nodone", 32'(instr_done), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step_expect("rs_restart", 4'h0);

        // run dropped during XOR1
        do_reset();
        instr_op = 4'h7;
        step_expect("x_fetch", 4'h0);
        step_expect("x_decode", 4'h1);
        step_expect("x_xor0", 4'hC);
        step_expect("x_xor1", 4'hD);
        run = 1'b0;
        step_expect("x_xor2", 4'hE);
        step_expect("x_idle", 4'hF);
        check("x_busy", 32'(busy), 32'd0);
        check("x_done", 32'(instr_done), 32'd1);
        check("x_count", 32'(instr_count), 32'd1);
        step_expect("x_hold", 4'hF);
        run = 1'b1;
        step_expect("x_resume", 4'h0);

        // Opcode F
        do_reset();
        instr_op = 4'hF;
        step_expect("f_fetch", 4'h0);
        step_expect("f_decode", 4'h1);
`ifdef CTRL_HALT_OPCODE_EN
        check("f_pcbump", 32'(pc_bump), 32'd0);
        step_expect("f_idle", 4'hF);
        check("f_halted", 32'(halted), 32'd1);
        check("f_done", 32'(instr_done), 32'd1);
        check("f_count", 32'(instr_count), 32'd1);
        for (int i = 0; i < 3; i++) step_expect("f_hold", 4'hF);
        reset = 1'b1;
        tick();
        check("f_halt_clr", 32'(halted), 32'd0);
        reset = 1'b0;
        step_expect("f_restart", 4'h0);
`else
        check("f_pcbump", 32'(pc_bump), 32'd1);
        step_expect("f_next", 4'h0);
        check("f_illegal", 32'(illegal), 32'd1);
        check("f_halted", 32'(halted), 32'd0);
        check("f_count", 32'(instr_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
